// File: rtl/wb_interconnect_nxm.sv
// wb_interconnect_nxm: Wishbone B4 classic NMxNS interconnect, round-robin grant, mask/base decode, unmapped/timeout errors; i_m_* master side in, o_s_* slave side out, o_err_adr/o_err_cnt error log
module wb_interconnect_nxm #(
  parameter int NM = 2,
  parameter int NS = 3,
  parameter logic [NS*32-1:0] SLAVE_BASE = {32'h4000_0000, 32'h8000_0000, 32'h0000_0000},
  parameter logic [NS*32-1:0] SLAVE_MASK = {32'hFFFF_F000, 32'hFF80_0000, 32'hFFFF_0000},
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             in_rst,
  input  logic [NM-1:0]    i_m_cyc,
  input  logic [NM-1:0]    i_m_stb,
  input  logic [NM-1:0]    i_m_we,
  input  logic [NM*32-1:0] i_m_adr,
  input  logic [NM*32-1:0] i_m_dat,
  input  logic [NM*4-1:0]  i_m_sel,
  output logic [NM-1:0]    o_m_ack,
  output logic [NM-1:0]    o_m_err,
  output logic [NM-1:0]    o_m_stall,
  output logic [31:0]      o_m_dat,
  output logic [NS-1:0]    o_s_cyc,
  output logic [NS-1:0]    o_s_stb,
  output logic             o_s_we,
  output logic [31:0]      o_s_adr,
  output logic [31:0]      o_s_dat,
  output logic [3:0]       o_s_sel,
  input  logic [NS-1:0]    i_s_ack,
  input  logic [NS-1:0]    i_s_stall,
  input  logic [NS*32-1:0] i_s_dat,
  output logic [31:0]      o_err_adr,
  output logic [7:0]       o_err_cnt
);
  localparam int GW = NM > 1 ? $clog2(NM) : 1;
  localparam int SW = NS > 1 ? $clog2(NS) : 1;
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ACCESS, ERR} state_t;
  state_t state, state_n;
  logic [GW-1:0] g, g_n, lp, lp_n, pick;
  logic [SW-1:0] s, s_n, hit_idx;
  logic [TW-1:0] tc, tc_n;
  logic [31:0] err_adr_n;
  logic [31:0] m_adr [NM];
  logic [31:0] m_dat [NM];
  logic [3:0] m_sel [NM];
  logic [31:0] s_dat [NS];
  logic req_any, hit, idle, acc, ack, abort, tmo, unmapped, err_inc;
  int best;
  for (genvar i = 0; i < NM; i++) begin : g_m
    assign m_adr[i] = i_m_adr[32*i +: 32];
    assign m_dat[i] = i_m_dat[32*i +: 32];
    assign m_sel[i] = i_m_sel[4*i +: 4];
  end
  for (genvar i = 0; i < NS; i++) begin : g_s
    assign s_dat[i] = i_s_dat[32*i +: 32];
  end
  always_comb begin
    req_any = 1'b0;
    pick = '0;
    best = NM;
    for (int i = 0; i < NM; i++)
      if (i_m_cyc[i] && i_m_stb[i] && ((i + NM - 1 - int'(lp)) % NM) < best) begin
        best = (i + NM - 1 - int'(lp)) % NM;
        pick = GW'(i);
        req_any = 1'b1;
      end
    hit = 1'b0;
    hit_idx = '0;
    for (int i = NS - 1; i >= 0; i--)
      if ((m_adr[pick] & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        hit = 1'b1;
        hit_idx = SW'(i);
      end
  end
  assign idle = state == IDLE;
  assign acc = state == ACCESS;
  assign ack = i_s_ack[s];
  assign abort = ~i_m_cyc[g];
  assign tmo = acc && tc == TW'(TIMEOUT - 1) && !ack && !abort;
  assign unmapped = idle && req_any && !hit;
  assign err_inc = unmapped || tmo;
  always_comb begin
    state_n = idle ? (req_any ? (hit ? ACCESS : ERR) : IDLE) : acc ? ((abort || ack || tmo) ? IDLE : ACCESS) : IDLE;
    g_n = idle && req_any ? pick : g;
    lp_n = idle && req_any ? pick : lp;
    s_n = idle && req_any && hit ? hit_idx : s;
    tc_n = acc ? tc + TW'(1) : '0;
    err_adr_n = unmapped ? m_adr[pick] : tmo ? m_adr[g] : o_err_adr;
  end
  always_ff @(posedge i_clk)
    if (!in_rst) begin
      state <= IDLE;
      g <= '0;
      s <= '0;
      lp <= GW'(NM - 1);
      tc <= '0;
      o_err_adr <= '0;
      o_err_cnt <= '0;
    end else begin
      state <= state_n;
      g <= g_n;
      s <= s_n;
      lp <= lp_n;
      tc <= tc_n;
      o_err_adr <= err_adr_n;
      if (err_inc && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
    end
  always_comb begin
    o_m_ack = '0;
    o_m_err = '0;
    o_m_stall = '1;
    o_m_dat = '0;
    o_s_cyc = '0;
    o_s_stb = '0;
    o_s_we = 1'b0;
    o_s_adr = '0;
    o_s_dat = '0;
    o_s_sel = '0;
    if (acc) begin
      o_s_cyc[s] = 1'b1;
      o_s_stb[s] = i_m_stb[g];
      o_s_we = i_m_we[g];
      o_s_adr = m_adr[g];
      o_s_dat = m_dat[g];
      o_s_sel = m_sel[g];
      o_m_ack[g] = ack && !abort;
      o_m_dat = s_dat[s];
      o_m_stall[g] = i_s_stall[s];
      o_m_err[g] = tmo;
    end
    if (state == ERR) o_m_err[g] = 1'b1;
  end
endmodule

// File: tb/tb_wb_interconnect_nxm.sv
// tb_wb_interconnect_nxm: scoreboard bench for the 2x3 interconnect with TIMEOUT=8
module tb_wb_interconnect_nxm;
  logic i_clk = 1'b0, in_rst = 1'b0;
  logic [1:0] m_cyc, m_stb, m_we, m_ack, m_err, m_stall;
  logic [63:0] m_adr, m_dat;
  logic [7:0] m_sel, err_cnt;
  logic [31:0] m_rdat, s_adr, s_wdat, err_adr;
  logic [2:0] s_cyc, s_stb, s_ack, s_stall;
  logic s_we;
  logic [3:0] s_sel;
  logic [95:0] s_rdat;
  logic [7:0] lat [3];
  logic [7:0] cnt [3];
  typedef struct {int m; bit err; logic [31:0] dat; logic [31:0] adr; logic [2:0] cyc;} exp_t;
  exp_t q[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0, resp_cnt = 0;
  always #5 i_clk = ~i_clk;
  wb_interconnect_nxm #(.NM(2), .NS(3), .TIMEOUT(8)) dut (
    .i_clk(i_clk), .in_rst(in_rst),
    .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we), .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel),
    .o_m_ack(m_ack), .o_m_err(m_err), .o_m_stall(m_stall), .o_m_dat(m_rdat),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_adr(s_adr), .o_s_dat(s_wdat), .o_s_sel(s_sel),
    .i_s_ack(s_ack), .i_s_stall(s_stall), .i_s_dat(s_rdat),
    .o_err_adr(err_adr), .o_err_cnt(err_cnt)
  );
  assign s_stall = 3'b000;
  assign s_rdat = {32'h2222_0002, 32'h1111_0001, 32'hDEAD_BEEF};
  always_comb
    for (int j = 0; j < 3; j++) s_ack[j] = s_cyc[j] & s_stb[j] & (cnt[j] == lat[j]);
  always @(posedge i_clk)
    for (int j = 0; j < 3; j++) cnt[j] <= (in_rst && s_cyc[j] && s_stb[j] && !s_ack[j]) ? cnt[j] + 8'd1 : 8'd0;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endfunction
  always @(negedge i_clk)
    if (in_rst)
      for (int m = 0; m < 2; m++)
        if (m_ack[m] || m_err[m]) begin
          resp_cnt++;
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_resp: master %0d ack=%b err=%b, required no response", m, m_ack[m], m_err[m]);
          end else begin
            e = q.pop_front();
            chk("resp_master", 32'(m), 32'(e.m));
            chk("resp_err", 32'(m_err[m]), 32'(e.err));
            chk("resp_scyc", 32'(s_cyc), 32'(e.cyc));
            chk("resp_other_stall", 32'(m_stall[1-m]), 32'd1);
            if (!e.err) begin
              chk("resp_dat", m_rdat, e.dat);
              chk("resp_adr", s_adr, e.adr);
            end
          end
        end
  task automatic set_m(input int m, input logic on, input logic we, input logic [31:0] adr);
    m_cyc[m] = on;
    m_stb[m] = on;
    m_we[m] = we;
    m_adr[32*m +: 32] = adr;
    m_dat[32*m +: 32] = adr ^ 32'hA5A5_A5A5;
  endtask
  task automatic push(input int m, input bit err, input logic [31:0] dat, input logic [31:0] adr, input logic [2:0] cyc);
    q.push_back('{m, err, dat, adr, cyc});
  endtask
  task automatic wait_resp(input int target, input string name);
    int k = 0;
    while (resp_cnt < target && k < 40) begin
      @(posedge i_clk);
      k++;
    end
    n_cmp++;
    if (resp_cnt < target) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d responses, required %0d", name, resp_cnt, target);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end
  initial begin
    int base;
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = 8'hFF;
    lat[0] = 8'd0; lat[1] = 8'd1; lat[2] = 8'd1;
    repeat (3) @(posedge i_clk);
    #1 in_rst = 1'b1;
    chk("rst_stall", 32'(m_stall), 32'h3);
    chk("rst_scyc", 32'(s_cyc), 32'h0);
    chk("rst_ack_err", 32'({m_ack, m_err}), 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
    chk("rst_err_adr", err_adr, 32'h0);
    base = resp_cnt;
    push(0, 0, 32'hDEAD_BEEF, 32'h0000_0100, 3'b001);
    set_m(0, 1, 0, 32'h0000_0100);
    @(posedge i_clk); #1;
    chk("read_ack_n1", 32'(m_ack), 32'h1);
    chk("read_scyc", 32'(s_cyc), 32'h1);
    wait_resp(base + 1, "read");
    #1 set_m(0, 0, 0, 0);
    push(1, 1, 0, 0, 3'b000);
    set_m(1, 1, 0, 32'h2000_0000);
    @(posedge i_clk); #1;
    chk("unm_err", 32'(m_err), 32'h2);
    chk("unm_scyc", 32'(s_cyc), 32'h0);
    @(posedge i_clk); #1;
    chk("unm_err_once", 32'(m_err), 32'h0);
    chk("unm_err_adr", err_adr, 32'h2000_0000);
    chk("unm_err_cnt", 32'(err_cnt), 32'h1);
    set_m(1, 0, 0, 0);
    base = resp_cnt;
    for (int i = 0; i < 2; i++) begin
      push(0, 0, 32'h2222_0002, 32'h4000_0004, 3'b100);
      push(1, 0, 32'h1111_0001, 32'h8000_0010, 3'b010);
    end
    set_m(0, 1, 1, 32'h4000_0004);
    set_m(1, 1, 1, 32'h8000_0010);
    wait_resp(base + 4, "contention");
    #1 set_m(0, 0, 0, 0);
    set_m(1, 0, 0, 0);
    lat[1] = 8'hFF;
    push(0, 1, 32'h1111_0001, 0, 3'b010);
    set_m(0, 1, 0, 32'h8000_0000);
    repeat (8) @(posedge i_clk);
    #1 chk("to_err", 32'(m_err), 32'h1);
    @(posedge i_clk); #1;
    chk("to_scyc_drop", 32'(s_cyc), 32'h0);
    chk("to_err_cnt", 32'(err_cnt), 32'h2);
    chk("to_err_adr", err_adr, 32'h8000_0000);
    set_m(0, 0, 0, 0);
    lat[1] = 8'd0;
    base = resp_cnt;
    push(0, 0, 32'h1111_0001, 32'h8000_0100, 3'b010);
    set_m(0, 1, 0, 32'h8000_0100);
    wait_resp(base + 1, "post_timeout");
    #1 set_m(0, 0, 0, 0);
    lat[2] = 8'd2;
    set_m(0, 1, 1, 32'h4000_0008);
    repeat (3) @(posedge i_clk);
    #1 m_cyc[0] = 1'b0;
    #1;
    chk("abort_slave_ack", 32'(s_ack[2]), 32'h1);
    chk("abort_no_ack", 32'(m_ack), 32'h0);
    @(posedge i_clk); #1;
    chk("abort_idle", 32'(s_cyc), 32'h0);
    chk("abort_err_cnt", 32'(err_cnt), 32'h2);
    set_m(0, 0, 0, 0);
    lat[2] = 8'hFF;
    set_m(0, 1, 0, 32'h4000_0000);
    @(posedge i_clk); #1;
    chk("rst2_pre_scyc", 32'(s_cyc), 32'h4);
    in_rst = 1'b0;
    @(posedge i_clk); #1;
    in_rst = 1'b1;
    set_m(0, 0, 0, 0);
    chk("rst2_scyc", 32'(s_cyc), 32'h0);
    chk("rst2_err_cnt", 32'(err_cnt), 32'h0);
    chk("rst2_stall", 32'(m_stall), 32'h3);
    chk("rst2_ack_err", 32'({m_ack, m_err}), 32'h0);
    lat[1] = 8'd1;
    lat[2] = 8'd1;
    base = resp_cnt;
    push(0, 0, 32'h2222_0002, 32'h4000_0010, 3'b100);
    push(1, 0, 32'h1111_0001, 32'h8000_0020, 3'b010);
    set_m(0, 1, 0, 32'h4000_0010);
    set_m(1, 1, 0, 32'h8000_0020);
    wait_resp(base + 2, "post_reset");
    #1 set_m(0, 0, 0, 0);
    set_m(1, 0, 0, 0);
    repeat (3) @(posedge i_clk);
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_interconnect_nxm.md
# wb_interconnect_nxm

Parametrised Wishbone B4 classic-cycle interconnect: NM masters to NS slaves, with round-robin master arbitration, mask/base address decode, unmapped-address error response and per-access ack timeout. It replaces the fixed single-master, three-slave (BRAM / SDRAM / peripherals) arbiter in the system top level. It lets the CPU and a second bus master (e.g. the DMA engine) share all memory-mapped slaves.

## Interface
Parameters:
- NM, 2: number of masters (1..4).
- NS, 3: number of slaves (1..8).
- SLAVE_BASE, {32'h4000_0000, 32'h8000_0000, 32'h0000_0000}: NS×32 flattened base addresses; slave i at bits [32i+31:32i].
- SLAVE_MASK, {32'hFFFF_F000, 32'hFF80_0000, 32'hFFFF_0000}: NS×32 flattened masks. Slave i matches when (adr & mask_i) == base_i.
- TIMEOUT, 255: maximum ACCESS cycles without slave ack (≥2).

Ports:
- i_clk  in  1  system clock
- in_rst  in  1  synchronous, active-low reset
- i_m_cyc, i_m_stb, i_m_we  in  NM each  master cycle / strobe / write enable
- i_m_adr, i_m_dat  in  NM×32 each  master address / write data
- i_m_sel  in  NM×4  master byte selects
- o_m_ack, o_m_err, o_m_stall  out  NM each  per-master ack / error / stall
- o_m_dat  out  32  read data, shared by all masters
- o_s_cyc, o_s_stb  out  NS each  per-slave cycle / strobe
- o_s_we  out  1  shared write enable
- o_s_adr, o_s_dat  out  32 each  shared address / write data
- o_s_sel  out  4  shared byte selects
- i_s_ack, i_s_stall  in  NS each  per-slave ack / stall
- i_s_dat  in  NS×32  per-slave read data
- o_err_adr  out  32  address of the most recent errored access
- o_err_cnt  out  8  count of errors, saturating

## Operation
- State machine: IDLE, ACCESS, ERR.
- Registers: grant index g, slave index s, last-grant pointer lp, timeout counter tc.

IDLE:
- Requests are i_m_cyc[i] & i_m_stb[i].
- If any request is present, grant the first requesting master searching lp+1, lp+2, … modulo NM. Set g and lp.
- Decode i_m_adr[g]. The lowest-index matching slave wins.
- If a slave matches, set s, clear tc and go to ACCESS.
- If no slave matches, latch o_err_adr and go to ERR.

ACCESS:
- Slave side: o_s_cyc[s]=1, o_s_stb[s]=i_m_stb[g]. o_s_we/adr/dat/sel carry master g's signals.
- Master side, combinational: o_m_ack[g]=i_s_ack[s], o_m_dat=i_s_dat[s], o_m_stall[g]=i_s_stall[s].
- i_s_ack[s] → go to IDLE.
- i_m_cyc[g]=0 (master abort) → go to IDLE, no ack.
- tc==TIMEOUT-1 without ack → o_m_err[g]=1 this cycle, latch o_err_adr, go to IDLE. Slave cyc drops the next cycle.
- Otherwise tc increments.

ERR:
- o_m_err[g]=1 for exactly one cycle, then go to IDLE.

Outputs and counters:
- Non-granted masters always see ack=0, err=0, stall=1.
- o_m_dat=0 outside ACCESS.
- o_s_* outputs are 0 outside ACCESS.
- o_err_cnt increments on every ERR entry and every timeout, saturating at 255.
- Slave ack in the same cycle as master abort is dropped (not forwarded).
- Acks from non-selected slaves are ignored.

Reset (in_rst=0 at a clock edge):
- State goes to IDLE, lp=NM-1 (so master 0 wins first), g=s=tc=0, o_err_adr=0, o_err_cnt=0.
- All outputs are 0 except o_m_stall, which is all ones.
- Reset mid-ACCESS aborts the transfer. No ack or err is issued for it.

## Timing
- Grant/decode latency: request seen in IDLE at cycle N → o_s_cyc asserted at N+1.
- A zero-wait slave acking at N+1 gives o_m_ack at N+1.
- The earliest next grant is the IDLE evaluation at N+2.
- Unmapped access: request at N, o_m_err at N+1.
- Timeout: ACCESS entered at N, no ack → o_m_err at N+TIMEOUT-1 → IDLE at N+TIMEOUT.
- Round robin: with two masters requesting continuously, grants alternate 0,1,0,1; no master waits more than NM-1 transactions.
- All decode and grant state is registered; the slave-to-master return path is combinational.

## Test plan
- Single master read from BRAM window: master 0 reads 0x0000_0100; slave 0 returns 0xDEADBEEF with ack at its first cycle → o_m_ack[0] at cycle N+1 with o_m_dat=0xDEADBEEF; o_s_cyc=3'b001 (bit 0 only).
- Contention: both masters hold write requests, master 0 to 0x4000_0004, master 1 to 0x8000_0010, slaves ack in 2 cycles → grant order 0,1,0,1; each master gets exactly one ack per transaction; o_s_adr matches the granted master.
- Unmapped address: master 1 reads 0x2000_0000 → o_m_err[1]=1 for exactly one cycle, no o_s_cyc assertion, o_err_adr=0x2000_0000, o_err_cnt=1.
- Timeout with TIMEOUT=8: SDRAM slave never acks → o_m_err pulses 7 cycles after ACCESS entry, o_s_cyc drops the next cycle, and the next request is then served normally.
- Master abort: master 0 drops cyc mid-ACCESS while the slave acks in the same cycle → no o_m_ack, FSM back in IDLE, o_err_cnt unchanged.
- Reset mid-ACCESS: in_rst low for one cycle during a slave wait → all o_s_cyc=0, o_err_cnt=0, o_m_stall all ones; the first post-reset grant goes to master 0.
